// File: rtl/rc4_ksa_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rc4_ksa_ctrl : RC4 key-scheduling sequencer driving an external 256x8 state
//                array. Optional abort input enabled by macro RC4_KSA_ABORT_EN.
// Revision     : 1.0 - initial release
// ----------------------------------------------------------------------------
module rc4_ksa_ctrl #(
  parameter int KEY_BYTES = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start_i,
  input  logic [8*KEY_BYTES-1:0] key_i,
`ifdef RC4_KSA_ABORT_EN
  input  logic                   abort_i,
`endif
  input  logic [7:0]             sarr_rdata_i,
  output logic [7:0]             sarr_waddr_o,
  output logic [7:0]             sarr_wdata_o,
  output logic [7:0]             sarr_raddr_o,
  output logic                   sarr_wenable_o,
  output logic                   sarr_renable_o,
  output logic                   sarr_swap_o,
  output logic                   busy_o,
  output logic                   done_o
);

  localparam int            KW     = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(KEY_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_INIT     = 3'd1,
    S_MIX_READ = 3'd2,
    S_MIX_SWAP = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [7:0]             i_q, i_d;
  logic [7:0]             j_q, j_d;
  logic [KW-1:0]          k_q, k_d;
  logic [8*KEY_BYTES-1:0] key_q, key_d;
  logic                   active_w;
  logic                   abort_w;
  logic [7:0]             key_byte_w;

  assign active_w = (state_q == S_INIT) || (state_q == S_MIX_READ) ||
                    (state_q == S_MIX_SWAP);

`ifdef RC4_KSA_ABORT_EN
  assign abort_w = abort_i & active_w;
`else
  assign abort_w = 1'b0;
`endif

  assign key_byte_w = key_q[{k_q, 3'b000} +: 8];

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    key_d   = key_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          key_d   = key_i;
          i_d     = 8'd0;
          j_d     = 8'd0;
          k_d     = '0;
          state_d = S_INIT;
        end
      end
      S_INIT: begin
        i_d = i_q + 8'd1;
        if (i_q == 8'hFF) state_d = S_MIX_READ;
      end
      S_MIX_READ: begin
        j_d     = j_q + sarr_rdata_i + key_byte_w;
        state_d = S_MIX_SWAP;
      end
      S_MIX_SWAP: begin
        i_d     = i_q + 8'd1;
        k_d     = (k_q == K_LAST) ? '0 : k_q + 1'b1;
        state_d = (i_q == 8'hFF) ? S_DONE : S_MIX_READ;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Abort overrides everything; the key register is left as is.
    if (abort_w) begin
      state_d = S_IDLE;
      i_d     = 8'd0;
      j_d     = 8'd0;
      k_d     = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      i_q     <= 8'd0;
      j_q     <= 8'd0;
      k_q     <= '0;
      key_q   <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      key_q   <= key_d;
    end
  end

  // Moore decode; j_q already holds the updated j during MIX_SWAP.
  always_comb begin
    sarr_waddr_o   = 8'd0;
    sarr_wdata_o   = 8'd0;
    sarr_raddr_o   = 8'd0;
    sarr_wenable_o = 1'b0;
    sarr_renable_o = 1'b0;
    sarr_swap_o    = 1'b0;
    if (!abort_w) begin
      case (state_q)
        S_INIT: begin
          sarr_wenable_o = 1'b1;
          sarr_waddr_o   = i_q;
          sarr_wdata_o   = i_q;
        end
        S_MIX_READ: begin
          sarr_renable_o = 1'b1;
          sarr_raddr_o   = i_q;
        end
        S_MIX_SWAP: begin
          sarr_swap_o  = 1'b1;
          sarr_raddr_o = i_q;
          sarr_waddr_o = j_q;
        end
        default: ;
      endcase
    end
  end

  assign busy_o = active_w;
  assign done_o = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: doc/rc4_ksa_ctrl.md
RC4_KSA_CTRL -- requirements
Module: rc4_ksa_ctrl

Interface
REQ-001 Parameter KEY_BYTES, default 16, key length in bytes; legal range 1..32.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start_i  input  1  request one key-scheduling run; accepted only in IDLE.
REQ-005 key_i  input  8*KEY_BYTES  key; byte k = key_i[8k+7:8k].
REQ-006 sarr_rdata_i  input  8  combinational read data from state array.
REQ-007 sarr_waddr_o  output  8  state-array write/swap address.
REQ-008 sarr_wdata_o  output  8  state-array write data.
REQ-009 sarr_raddr_o  output  8  state-array read/swap address.
REQ-010 sarr_wenable_o, sarr_renable_o, sarr_swap_o  output  1 each  state-array strobes.
REQ-011 busy_o  output  1  run in progress.
REQ-012 done_o  output  1  one-cycle pulse at run completion.

Function
REQ-013 States SHALL be IDLE, INIT, MIX_READ, MIX_SWAP, DONE; counters i[7:0], j[7:0], k (key index, 0..KEY_BYTES-1); key register key_q.
REQ-014 IDLE: start_i=1 -> latch key_q=key_i, i=0, j=0, k=0, go INIT; else stay.
REQ-015 start_i outside IDLE SHALL be ignored; key_i changes after acceptance SHALL have no effect.
REQ-016 INIT: wenable=1, waddr=i, wdata=i; i increments each cycle; at i=255 -> i wraps to 0, go MIX_READ (256 cycles total).
REQ-017 MIX_READ: renable=1, raddr=i; register j = (j + sarr_rdata_i + key_q byte k) mod 256; go MIX_SWAP.
REQ-018 MIX_SWAP: swap=1, raddr=i, waddr=j (updated value); i increments mod 256; k increments, wrapping KEY_BYTES-1 -> 0; if i was 255 go DONE, else MIX_READ.
REQ-019 i==j in MIX_SWAP SHALL still assert swap (array unchanged); no special case.
REQ-020 DONE: done_o=1 for exactly one cycle, busy_o=0, go IDLE.
REQ-021 busy_o=1 exactly in INIT, MIX_READ, MIX_SWAP.
REQ-022 At most one of wenable/swap high in any cycle; all strobes and addresses/data SHALL be 0 in IDLE and DONE and whenever not driven per REQ-016..018.
REQ-023 Latency: start_i accepted at edge 0 -> done_o high in cycle 769 (256 INIT + 512 MIX), busy_o high cycles 1..768.
REQ-024 Outputs SHALL be decoded from registered state/counters only (Moore), except abort gating in REQ-029.

Reset
REQ-025 reset=1 SHALL immediately, without clock, force IDLE, i=j=k=0, key_q=0.
REQ-026 During and after reset all outputs SHALL be 0; a run interrupted by reset leaves the array partially scheduled and is not resumed.
REQ-027 First start_i is accepted at the first rising edge after reset deasserts.

Configuration
REQ-028 Macro RC4_KSA_ABORT_EN SHALL add input abort_i (1 bit).
REQ-029 With RC4_KSA_ABORT_EN: abort_i=1 in INIT/MIX_READ/MIX_SWAP combinationally forces all strobes to 0 that cycle and next state IDLE, counters cleared, no done_o pulse; abort_i ignored in IDLE/DONE; abort_i and start_i both high in IDLE -> start accepted.
REQ-030 Without RC4_KSA_ABORT_EN: no abort_i port; a run is interruptible only by reset.

Verification
REQ-031 Start, key byte0=0x10 -> cycles 1..256 wenable with waddr=wdata=0x00..0xFF; cycle 257 renable raddr=0x00; cycle 258 swap raddr=0x00 waddr=0x10.
REQ-032 Key all 0x00 with model array attached -> done_o single pulse at cycle 769, final array equals software RC4 KSA for 16 zero bytes, busy_o=0 from cycle 769.
REQ-033 start_i held high plus key_i toggled during run -> exactly one done_o, result matches key latched at acceptance, next run starts only after IDLE.
REQ-034 KEY_BYTES=3, key 0x01,0x02,0x03 -> k sequence 0,1,2,0,... across MIX; final array matches software KSA for key "01 02 03".
REQ-035 reset asserted mid-MIX_SWAP between edges -> all outputs 0 immediately; new start after release runs full 769 cycles.
REQ-036 RC4_KSA_ABORT_EN, abort_i pulse in cycle 300 -> no swap that cycle, busy_o=0 in cycle 301, done_o never asserts.
